// File: rtl/vga_pkg.sv
// Shared VGA constants: default 640x480@60 timing, derived totals, and the
// videoGen board geometry that draws into the visible region.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Board drawn by videoGen: BOARD_SIZE x BOARD_SIZE cells, centred, with a frame.
  localparam int BOARD_SIZE = 8;
  localparam int CELL_SIZE  = 48;
  localparam int FRAME_W    = 4;
  localparam int BOARD_PIX  = BOARD_SIZE * CELL_SIZE;
  localparam int BOARD_X0   = (H_ACTIVE_DEF - BOARD_PIX) / 2;
  localparam int BOARD_Y0   = (V_ACTIVE_DEF - BOARD_PIX) / 2;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD counter: advances when en is high, wrap flags the enabled
// cycle on which the count returns from MOD-1 to 0. clear has priority.
module mod_counter #(
  parameter int MOD = 800,
  parameter int W   = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clear,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (en) begin
      value_d = (value_q == LAST) ? '0 : value_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value = value_q;
  assign wrap  = en && !clear && (value_q == LAST);

endmodule

// File: rtl/vga_timing.sv
// VGA sync/blank generator at half the system clock rate.
// Define VGA_TIMING_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       vgaclk,
  output logic       hsync,
  output logic       vsync,
  output logic       sync_b,
  output logic       blank_b,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);

  logic       pix_en_q, pix_en_d;
  logic [9:0] hcnt, vcnt;
  logic       h_wrap, v_wrap;

  assign pix_en_d = ~pix_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_en_q <= 1'b0;
    else        pix_en_q <= pix_en_d;
  end

  mod_counter #(.MOD(H_TOT), .W(10)) u_hcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en_q),
    .clear (1'b0),
    .value (hcnt),
    .wrap  (h_wrap)
  );

  // Vertical count steps once per line, on the same edge the line wraps.
  mod_counter #(.MOD(V_TOT), .W(10)) u_vcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (h_wrap),
    .clear (1'b0),
    .value (vcnt),
    .wrap  (v_wrap)
  );

  assign vgaclk      = pix_en_q;
  assign x           = hcnt;
  assign y           = vcnt;
  assign hsync       = !((hcnt >= HS_START) && (hcnt < HS_END));
  assign vsync       = !((vcnt >= VS_START) && (vcnt < VS_END));
  assign blank_b     = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign sync_b      = 1'b0;
  assign frame_start = v_wrap;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start) frame_cnt_d = frame_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= 8'd0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
